// File: rtl/modulo_tabuleiro_batalha_param_if.sv
// rtl/modulo_tabuleiro_batalha_param_if.sv - button/coordinate inputs and board/display outputs of the battleship controller
interface modulo_tabuleiro_batalha_param_if #(
  parameter int ROWS = 7,
  parameter int COLS = 5
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  logic                   button_confirmation;
  logic                   button_clear;
  logic [ROW_W+COL_W-1:0] coord_at;
  logic [2:0]             status;
  logic [5:0]             hits;
  logic                   game_over;
  logic [COLS-1:0]        m_col;
  logic [ROWS-1:0]        m_line;
  logic [3:0]             out_digit;
  logic [3:0]             out_7seg_ac;

  modport master (
    output button_confirmation, button_clear, coord_at,
    input  status, hits, game_over, m_col, m_line, out_digit, out_7seg_ac
  );

  modport slave (
    input  button_confirmation, button_clear, coord_at,
    output status, hits, game_over, m_col, m_line, out_digit, out_7seg_ac
  );
endinterface

// File: rtl/modulo_tabuleiro_batalha_param.sv
// rtl/modulo_tabuleiro_batalha_param.sv - battleship board controller with shot FSM, LED matrix scan and digit mux
module modulo_tabuleiro_batalha_param #(
  parameter int                   ROWS     = 7,
  parameter int                   COLS     = 5,
  parameter logic [ROWS*COLS-1:0] SHIP_MAP = '0,
  parameter int                   SCAN_DIV = 50000,
  parameter int                   BLINK_FR = 8
) (
  input logic                             clk,
  input logic                             clr,
  modulo_tabuleiro_batalha_param_if.slave bus
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FR_W  = $clog2(BLINK_FR) + 1;

  function automatic int count_ships(input logic [ROWS*COLS-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < ROWS * COLS; i++) n += int'(m[i]);
    return n;
  endfunction

  localparam int         SHIPS          = count_ships(SHIP_MAP);
  // With more ship cells than the 6-bit counter can hold the game can never end.
  localparam bit         OVER_REACHABLE = (SHIPS <= 63);
  localparam logic [5:0] SHIPS_6        = 6'(SHIPS);

  localparam logic [2:0] ST_READY   = 3'b000;
  localparam logic [2:0] ST_MISS    = 3'b001;
  localparam logic [2:0] ST_HIT     = 3'b010;
  localparam logic [2:0] ST_REPEAT  = 3'b011;
  localparam logic [2:0] ST_INVALID = 3'b100;
  localparam logic [2:0] ST_OVER    = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_OVER} state_t;

  state_t                 state_q;
  logic                   conf_prev_q, clear_prev_q, conf_rise_q, clear_rise_q;
  logic [ROW_W-1:0]       crd_row_q;
  logic [COL_W-1:0]       crd_col_q;
  logic [ROWS*COLS-1:0]   shots_q;
  logic [5:0]             hits_q;
  logic [2:0]             status_q;
  logic                   game_over_q;

  logic                   cell_valid, cell_ship, cell_shot;
  logic [ROWS*COLS-1:0]   cell_mask;
  logic [5:0]             hits_new;

  // Decode the latched coordinate by matching real cells, so unused encodings stay invalid.
  always_comb begin
    cell_valid = 1'b0;
    cell_ship  = 1'b0;
    cell_shot  = 1'b0;
    cell_mask  = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (crd_row_q == ROW_W'(r) && crd_col_q == COL_W'(c)) begin
          cell_valid             = 1'b1;
          cell_ship              = SHIP_MAP[r*COLS+c];
          cell_shot              = shots_q[r*COLS+c];
          cell_mask[r*COLS+c]    = 1'b1;
        end
      end
    end
    hits_new = (cell_ship && hits_q != 6'd63) ? hits_q + 6'd1 : hits_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      conf_prev_q  <= 1'b0;
      clear_prev_q <= 1'b0;
      conf_rise_q  <= 1'b0;
      clear_rise_q <= 1'b0;
      crd_row_q    <= '0;
      crd_col_q    <= '0;
      shots_q      <= '0;
      hits_q       <= '0;
      status_q     <= ST_READY;
      game_over_q  <= 1'b0;
    end else begin
      conf_prev_q  <= bus.button_confirmation;
      clear_prev_q <= bus.button_clear;
      conf_rise_q  <= bus.button_confirmation & ~conf_prev_q;
      clear_rise_q <= bus.button_clear & ~clear_prev_q;
      if (clear_rise_q) begin
        shots_q     <= '0;
        hits_q      <= '0;
        status_q    <= ST_READY;
        game_over_q <= 1'b0;
        state_q     <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (conf_rise_q) begin
              crd_row_q <= bus.coord_at[ROW_W+COL_W-1:COL_W];
              crd_col_q <= bus.coord_at[COL_W-1:0];
              state_q   <= S_CHECK;
            end
          end
          S_CHECK: begin
            state_q <= S_IDLE;
            if (!cell_valid) begin
              status_q <= ST_INVALID;
            end else if (cell_shot) begin
              status_q <= ST_REPEAT;
            end else begin
              shots_q  <= shots_q | cell_mask;
              hits_q   <= hits_new;
              status_q <= cell_ship ? ST_HIT : ST_MISS;
              if (OVER_REACHABLE && hits_new == SHIPS_6) begin
                status_q    <= ST_OVER;
                game_over_q <= 1'b1;
                state_q     <= S_OVER;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [DIV_W-1:0] div_q;
  logic [COL_W-1:0] col_q;
  logic [1:0]       dig_q;
  logic [FR_W-1:0]  frame_q;
  logic             blink_q;
  logic [COLS-1:0]  m_col_q;
  logic [ROWS-1:0]  m_line_q, line_d;
  logic [3:0]       ac_q, digit_q, digit_d;
  logic             tick;

  assign tick = (div_q == DIV_W'(SCAN_DIV - 1));

  // Hit cells light steadily; miss cells follow the blink phase.
  always_comb begin
    line_d = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (col_q == COL_W'(c))
          line_d[r] = shots_q[r*COLS+c] & (SHIP_MAP[r*COLS+c] | blink_q);
  end

  always_comb begin
    case (dig_q)
      2'd0:    digit_d = {1'b0, status_q};
      2'd1:    digit_d = 4'(crd_row_q);
      2'd2:    digit_d = 4'(crd_col_q);
      default: digit_d = (hits_q > 6'd15) ? 4'hF : hits_q[3:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_q    <= '0;
      col_q    <= '0;
      dig_q    <= '0;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      m_col_q  <= COLS'(1);
      m_line_q <= '0;
      ac_q     <= 4'b1110;
      digit_q  <= 4'd0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        dig_q <= dig_q + 2'd1;
        if (col_q == COL_W'(COLS - 1)) begin
          col_q <= '0;
          if (frame_q == FR_W'(BLINK_FR - 1)) begin
            frame_q <= '0;
            blink_q <= ~blink_q;
          end else begin
            frame_q <= frame_q + FR_W'(1);
          end
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      m_col_q  <= COLS'(1) << col_q;
      m_line_q <= line_d;
      ac_q     <= ~(4'b0001 << dig_q);
      digit_q  <= digit_d;
    end
  end

  assign bus.status      = status_q;
  assign bus.hits        = hits_q;
  assign bus.game_over   = game_over_q;
  assign bus.m_col       = m_col_q;
  assign bus.m_line      = m_line_q;
  assign bus.out_digit   = digit_q;
  assign bus.out_7seg_ac = ac_q;
endmodule

// File: tb/tb_modulo_tabuleiro_batalha_param.sv
// tb/tb_modulo_tabuleiro_batalha_param.sv - self-checking bench for the battleship board controller
module tb_modulo_tabuleiro_batalha_param;
  localparam logic [34:0] MAP1 = 35'h400002001;  // ships at (0,0), (2,3), (6,4)

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (clr) n_cyc <= 0;
    else     n_cyc <= n_cyc + 1;
  end

  modulo_tabuleiro_batalha_param_if #(.ROWS(7), .COLS(5)) b1 ();
  modulo_tabuleiro_batalha_param_if #(.ROWS(4), .COLS(4)) b2 ();

  modulo_tabuleiro_batalha_param #(
    .ROWS(7), .COLS(5), .SHIP_MAP(MAP1), .SCAN_DIV(4), .BLINK_FR(2)
  ) dut1 (.clk(clk), .clr(clr), .bus(b1));

  modulo_tabuleiro_batalha_param #(
    .ROWS(4), .COLS(4), .SHIP_MAP(16'hFFFF), .SCAN_DIV(4), .BLINK_FR(1)
  ) dut2 (.clk(clk), .clr(clr), .bus(b2));

  // Reference model: plain per-board arrays driven by the game rules.
  bit         ship_m [2][16][16];
  bit         shot_m [2][16][16];
  int         exp_hits [2];
  logic [2:0] exp_st [2];
  bit         exp_over [2];
  int         ships_total [2];
  int         last_row [2];
  int         last_col [2];
  int         rows_b [2] = '{7, 4};
  int         cols_b [2] = '{5, 4};

  task automatic model_clear(input int b);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) shot_m[b][r][c] = 1'b0;
    exp_hits[b] = 0;
    exp_st[b]   = 3'd0;
    exp_over[b] = 1'b0;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      model_clear(b);
      last_row[b] = 0;
      last_col[b] = 0;
    end
  endtask

  task automatic model_fire(input int b, input int r, input int c);
    if (exp_over[b]) return;
    last_row[b] = r;
    last_col[b] = c;
    if (r >= rows_b[b] || c >= cols_b[b]) exp_st[b] = 3'd4;
    else if (shot_m[b][r][c]) exp_st[b] = 3'd3;
    else begin
      shot_m[b][r][c] = 1'b1;
      if (ship_m[b][r][c] && exp_hits[b] < 63) exp_hits[b]++;
      exp_st[b] = ship_m[b][r][c] ? 3'd2 : 3'd1;
      if (exp_hits[b] == ships_total[b]) begin
        exp_st[b]   = 3'd5;
        exp_over[b] = 1'b1;
      end
    end
  endtask

  task automatic press(input int b, input int r, input int c);
    @(negedge clk);
    if (b == 0) begin
      b1.coord_at = {3'(r), 3'(c)};
      b1.button_confirmation = 1'b1;
    end else begin
      b2.coord_at = {2'(r), 2'(c)};
      b2.button_confirmation = 1'b1;
    end
  endtask

  task automatic fire(input int b, input int r, input int c);
    model_fire(b, r, c);
    press(b, r, c);
    @(negedge clk);
    b1.button_confirmation = 1'b0;
    b2.button_confirmation = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear(input int b);
    @(negedge clk);
    if (b == 0) b1.button_clear = 1'b1;
    else        b2.button_clear = 1'b1;
    @(negedge clk);
    b1.button_clear = 1'b0;
    b2.button_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_clear(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (b1.status !== 3'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", b1.status); end
    checks++; if (b1.hits !== 6'd0) begin failures++; $display("FAIL reset_hits got=%0d exp=0", b1.hits); end
    checks++; if (b1.game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%0b exp=0", b1.game_over); end
    checks++; if (b1.m_col !== 5'b00001) begin failures++; $display("FAIL reset_m_col got=%b exp=00001", b1.m_col); end
    checks++; if (b1.m_line !== 7'd0) begin failures++; $display("FAIL reset_m_line got=%b exp=0", b1.m_line); end
    checks++; if (b1.out_7seg_ac !== 4'b1110) begin failures++; $display("FAIL reset_anode got=%b exp=1110", b1.out_7seg_ac); end
    checks++; if (b1.out_digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", b1.out_digit); end
    checks++; if (b2.m_col !== 4'b0001) begin failures++; $display("FAIL reset_m_col4 got=%b exp=0001", b2.m_col); end
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_hit();
    do_reset();
    model_fire(0, 2, 3);
    press(0, 2, 3);
    @(negedge clk);
    b1.button_confirmation = 1'b0;
    @(negedge clk);
    checks++; if (b1.status !== 3'd0) begin failures++; $display("FAIL hit_early_status got=%0d exp=0", b1.status); end
    @(negedge clk);
    checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL hit_status got=%0d exp=%0d", b1.status, exp_st[0]); end
    checks++; if (b1.hits !== 6'(exp_hits[0])) begin failures++; $display("FAIL hit_hits got=%0d exp=%0d", b1.hits, exp_hits[0]); end
    checks++; if (b1.game_over !== 1'b0) begin failures++; $display("FAIL hit_game_over got=%0b exp=0", b1.game_over); end
  endtask

  task automatic test_repeat_invalid();
    int cr [4] = '{2, 7, 0, 6};
    int cc [4] = '{3, 3, 5, 7};
    for (int i = 0; i < 4; i++) begin
      fire(0, cr[i], cc[i]);
      checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL rep_inv_status[%0d] got=%0d exp=%0d", i, b1.status, exp_st[0]); end
      checks++; if (b1.hits !== 6'(exp_hits[0])) begin failures++; $display("FAIL rep_inv_hits[%0d] got=%0d exp=%0d", i, b1.hits, exp_hits[0]); end
    end
  endtask

  task automatic test_hold_and_clear_race();
    do_reset();
    model_fire(0, 1, 1);
    press(0, 1, 1);
    repeat (100) @(negedge clk);
    checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL hold_status got=%0d exp=%0d", b1.status, exp_st[0]); end
    b1.button_confirmation = 1'b0;
    @(negedge clk);
    fire(0, 1, 1);
    checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL hold_refire got=%0d exp=%0d", b1.status, exp_st[0]); end
    @(negedge clk);
    b1.coord_at = {3'd2, 3'd3};
    b1.button_confirmation = 1'b1;
    b1.button_clear = 1'b1;
    @(negedge clk);
    b1.button_confirmation = 1'b0;
    b1.button_clear = 1'b0;
    repeat (3) @(negedge clk);
    model_clear(0);
    checks++; if (b1.status !== 3'd0) begin failures++; $display("FAIL race_status got=%0d exp=0", b1.status); end
    fire(0, 1, 1);
    checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL race_shots_cleared got=%0d exp=%0d", b1.status, exp_st[0]); end
  endtask

  task automatic test_game_over();
    int sr [4] = '{0, 2, 6, 1};
    int sc [4] = '{0, 3, 4, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fire(0, sr[i], sc[i]);
      checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL over_status[%0d] got=%0d exp=%0d", i, b1.status, exp_st[0]); end
      checks++; if (b1.hits !== 6'(exp_hits[0])) begin failures++; $display("FAIL over_hits[%0d] got=%0d exp=%0d", i, b1.hits, exp_hits[0]); end
      checks++; if (b1.game_over !== exp_over[0]) begin failures++; $display("FAIL over_flag[%0d] got=%0b exp=%0b", i, b1.game_over, exp_over[0]); end
    end
    do_clear(0);
    checks++; if (b1.hits !== 6'd0 || b1.game_over !== 1'b0 || b1.status !== 3'd0) begin
      failures++; $display("FAIL over_clear got=%0d/%0b/%0d exp=0/0/0", b1.hits, b1.game_over, b1.status);
    end
    fire(0, 1, 1);
    checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL over_after_clear got=%0d exp=%0d", b1.status, exp_st[0]); end
  endtask

  task automatic test_scan();
    int s, col, dig;
    bit blink;
    logic [6:0] el;
    logic [3:0] ed;
    do_reset();
    fire(0, 2, 3);
    fire(0, 1, 3);
    for (int k = 0; k < 420; k++) begin
      @(negedge clk);
      s = (n_cyc - 1) / 4;
      col = s % 5;
      dig = s % 4;
      blink = ((s / 10) % 2) == 1;
      for (int r = 0; r < 7; r++) el[r] = shot_m[0][r][col] & (ship_m[0][r][col] | blink);
      case (dig)
        0:       ed = 4'(exp_st[0]);
        1:       ed = 4'(last_row[0]);
        2:       ed = 4'(last_col[0]);
        default: ed = (exp_hits[0] > 15) ? 4'd15 : 4'(exp_hits[0]);
      endcase
      checks++; if (b1.m_col !== 5'(1 << col)) begin failures++; $display("FAIL scan_m_col n=%0d got=%b exp=%b", n_cyc, b1.m_col, 5'(1 << col)); end
      checks++; if (b1.out_7seg_ac !== ~4'(1 << dig)) begin failures++; $display("FAIL scan_anode n=%0d got=%b exp=%b", n_cyc, b1.out_7seg_ac, ~4'(1 << dig)); end
      checks++; if (b1.m_line !== el) begin failures++; $display("FAIL scan_m_line n=%0d got=%b exp=%b", n_cyc, b1.m_line, el); end
      checks++; if (b1.out_digit !== ed) begin failures++; $display("FAIL scan_digit n=%0d got=%0d exp=%0d", n_cyc, b1.out_digit, ed); end
    end
  endtask

  task automatic test_random();
    int sr [3] = '{0, 2, 6};
    int sc [3] = '{0, 3, 4};
    int sel, pick;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) do_clear(0);
      else if (sel <= 3) begin
        pick = int'($urandom_range(0, 2));
        fire(0, sr[pick], sc[pick]);
      end else fire(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      checks++; if (b1.status !== exp_st[0]) begin failures++; $display("FAIL rand_status[%0d] got=%0d exp=%0d", i, b1.status, exp_st[0]); end
      checks++; if (b1.hits !== 6'(exp_hits[0])) begin failures++; $display("FAIL rand_hits[%0d] got=%0d exp=%0d", i, b1.hits, exp_hits[0]); end
      checks++; if (b1.game_over !== exp_over[0]) begin failures++; $display("FAIL rand_over[%0d] got=%0b exp=%0b", i, b1.game_over, exp_over[0]); end
    end
  endtask

  task automatic test_full_board();
    int order [16];
    int j, t;
    bit seen;
    do_reset();
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 16; i++) begin
      fire(1, order[i] / 4, order[i] % 4);
      checks++; if (b2.status !== exp_st[1]) begin failures++; $display("FAIL full_status[%0d] got=%0d exp=%0d", i, b2.status, exp_st[1]); end
      checks++; if (b2.hits !== 6'(exp_hits[1])) begin failures++; $display("FAIL full_hits[%0d] got=%0d exp=%0d", i, b2.hits, exp_hits[1]); end
      checks++; if (b2.game_over !== exp_over[1]) begin failures++; $display("FAIL full_over[%0d] got=%0b exp=%0b", i, b2.game_over, exp_over[1]); end
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (b2.out_7seg_ac == 4'b0111) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL full_digit3 got=timeout exp=anode 0111"); end
    else if (b2.out_digit !== 4'd15) begin failures++; $display("FAIL full_digit3 got=%0d exp=15", b2.out_digit); end
    do_clear(1);
    model_fire(1, 0, 0);
    press(1, 0, 0);
    @(negedge clk);
    b2.button_confirmation = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++; if (b2.status !== 3'd0 || b2.hits !== 6'd0 || b2.game_over !== 1'b0) begin
      failures++; $display("FAIL midcheck_clr got=%0d/%0d/%0b exp=0/0/0", b2.status, b2.hits, b2.game_over);
    end
    checks++; if (b2.m_col !== 4'b0001 || b2.m_line !== 4'd0 || b2.out_7seg_ac !== 4'b1110 || b2.out_digit !== 4'd0) begin
      failures++; $display("FAIL midcheck_scan got=%b/%b/%b/%0d exp=0001/0000/1110/0", b2.m_col, b2.m_line, b2.out_7seg_ac, b2.out_digit);
    end
    clr = 1'b0;
    model_reset();
    fire(1, 0, 0);
    checks++; if (b2.status !== exp_st[1]) begin failures++; $display("FAIL midcheck_after got=%0d exp=%0d", b2.status, exp_st[1]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.button_confirmation = 1'b0; b1.button_clear = 1'b0; b1.coord_at = '0;
    b2.button_confirmation = 1'b0; b2.button_clear = 1'b0; b2.coord_at = '0;
    ships_total[0] = 0;
    ships_total[1] = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        ship_m[0][r][c] = (r < 7 && c < 5) ? MAP1[r*5+c] : 1'b0;
        ship_m[1][r][c] = (r < 4 && c < 4);
        ships_total[0] += int'(ship_m[0][r][c]);
        ships_total[1] += int'(ship_m[1][r][c]);
      end
    end
    model_reset();
    test_reset();
    test_hit();
    test_repeat_invalid();
    test_hold_and_clear_race();
    test_game_over();
    test_scan();
    test_random();
    test_full_board();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
